// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : 2-read/1-write register file with a per-register busy
//               scoreboard, write-to-read bypass, a bulk-clear sequencer and
//               a registered debug read port.
// Ports       : clk, reset (async, active-high)
//               rd_addr_a/b -> rd_data_a/b, rd_busy_a/b   (combinational)
//               wr_en/wr_addr/wr_data                     write-back
//               rsv_en/rsv_addr -> rsv_conflict           reserve
//               clr_req -> clr_busy, clr_done             bulk clear
//               wr_drop                                   dropped wr/rsv
//               dbg_addr -> dbg_data                      1-cycle latency
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  rd_busy_a,
  output logic                  rd_busy_b,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic                  rsv_conflict,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  wr_drop,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int                  c_N_REG = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_LAST = '1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_index;
  logic [DATA_WIDTH-1:0]   r_mem [c_N_REG];
  logic [c_N_REG-1:0]      r_busy;

  logic w_clearing;
  logic w_wr_ok;
  logic w_rsv_ok;
  logic w_rd_zero_a;
  logic w_rd_zero_b;

  assign w_clearing = (r_state == ST_CLEAR);

  // Register 0 is hard-wired when ZERO_REG is set: writes and reserves to it
  // are simply not accepted, so its storage and busy bit never leave zero.
  assign w_wr_ok  = wr_en  && !w_clearing && !((ZERO_REG != 0) && (wr_addr  == '0));
  assign w_rsv_ok = rsv_en && !w_clearing && !((ZERO_REG != 0) && (rsv_addr == '0));

  assign w_rd_zero_a = (ZERO_REG != 0) && (rd_addr_a == '0);
  assign w_rd_zero_b = (ZERO_REG != 0) && (rd_addr_b == '0);

  // Bypass only forwards accepted writes, so it is implicitly off during a
  // clear and for the hard-wired zero register.
  always_comb begin
    rd_data_a = r_mem[rd_addr_a];
    if (w_rd_zero_a)
      rd_data_a = '0;
    else if ((BYPASS != 0) && w_wr_ok && (wr_addr == rd_addr_a))
      rd_data_a = wr_data;
  end

  always_comb begin
    rd_data_b = r_mem[rd_addr_b];
    if (w_rd_zero_b)
      rd_data_b = '0;
    else if ((BYPASS != 0) && w_wr_ok && (wr_addr == rd_addr_b))
      rd_data_b = wr_data;
  end

  assign rd_busy_a = !w_rd_zero_a && r_busy[rd_addr_a];
  assign rd_busy_b = !w_rd_zero_b && r_busy[rd_addr_b];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_N_REG; i++)
        r_mem[i] <= '0;
      r_busy       <= '0;
      r_state      <= ST_IDLE;
      r_index      <= '0;
      clr_busy     <= 1'b0;
      clr_done     <= 1'b0;
      rsv_conflict <= 1'b0;
      wr_drop      <= 1'b0;
      dbg_data     <= '0;
    end else begin
      dbg_data <= r_mem[dbg_addr];
      clr_done <= 1'b0;
      // A same-cycle write to the reserved register retires the old
      // producer, so re-reserving it is legitimate and not a conflict.
      rsv_conflict <= w_rsv_ok && r_busy[rsv_addr] &&
                      !(w_wr_ok && (wr_addr == rsv_addr));
      wr_drop      <= w_clearing && (wr_en || rsv_en);

      if (w_wr_ok) begin
        r_mem[wr_addr]  <= wr_data;
        r_busy[wr_addr] <= 1'b0;
      end
      // Placed after the write so reserve wins on a shared address.
      if (w_rsv_ok)
        r_busy[rsv_addr] <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (clr_req) begin
            r_state  <= ST_CLEAR;
            r_index  <= '0;
            clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_mem[r_index]  <= '0;
          r_busy[r_index] <= 1'b0;
          r_index         <= r_index + 1'b1;
          if (r_index == c_LAST) begin
            r_state  <= ST_IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Directed bench for regfile_scoreboard. Two instances share the
//               stimulus: dut0 (ZERO_REG=0, BYPASS=1) and dut1 (ZERO_REG=1,
//               BYPASS=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

  logic        clk;
  logic        reset;
  logic [3:0]  rd_addr_a, rd_addr_b, wr_addr, rsv_addr, dbg_addr;
  logic [15:0] wr_data;
  logic        wr_en, rsv_en, clr_req;

  logic [15:0] d0_rd_data_a, d0_rd_data_b, d0_dbg_data;
  logic        d0_rd_busy_a, d0_rd_busy_b, d0_rsv_conflict;
  logic        d0_clr_busy, d0_clr_done, d0_wr_drop;
  logic [15:0] d1_rd_data_a, d1_rd_data_b, d1_dbg_data;
  logic        d1_rd_busy_a, d1_rd_busy_b, d1_rsv_conflict;
  logic        d1_clr_busy, d1_clr_done, d1_wr_drop;

  int total = 0;
  int bad   = 0;

  regfile_scoreboard #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .ZERO_REG(0), .BYPASS(1)) dut0 (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(d0_rd_data_a), .rd_data_b(d0_rd_data_b),
    .rd_busy_a(d0_rd_busy_a), .rd_busy_b(d0_rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_conflict(d0_rsv_conflict),
    .clr_req(clr_req), .clr_busy(d0_clr_busy), .clr_done(d0_clr_done),
    .wr_drop(d0_wr_drop), .dbg_addr(dbg_addr), .dbg_data(d0_dbg_data)
  );

  regfile_scoreboard #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .ZERO_REG(1), .BYPASS(0)) dut1 (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(d1_rd_data_a), .rd_data_b(d1_rd_data_b),
    .rd_busy_a(d1_rd_busy_a), .rd_busy_b(d1_rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_conflict(d1_rsv_conflict),
    .clr_req(clr_req), .clr_busy(d1_clr_busy), .clr_done(d1_clr_done),
    .wr_drop(d1_wr_drop), .dbg_addr(dbg_addr), .dbg_data(d1_dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1; wr_en = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; rsv_addr = '0;
    dbg_addr = '0; wr_data = '0;
    #2;

    // 1: reset state on every address
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i);
      rd_addr_b = 4'(15 - i);
      #1;
      chk("rst_data_a", {16'h0, d0_rd_data_a}, 32'h0);
      chk("rst_data_b", {16'h0, d0_rd_data_b}, 32'h0);
      chk("rst_busy_a", {31'h0, d0_rd_busy_a}, 32'h0);
      chk("rst_busy_b", {31'h0, d0_rd_busy_b}, 32'h0);
    end
    chk("rst_dbg",      {16'h0, d0_dbg_data}, 32'h0);
    chk("rst_clr_busy", {31'h0, d0_clr_busy}, 32'h0);
    chk("rst_clr_done", {31'h0, d0_clr_done}, 32'h0);
    chk("rst_conflict", {31'h0, d0_rsv_conflict}, 32'h0);
    chk("rst_wr_drop",  {31'h0, d0_wr_drop}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // 2: bypass vs. no bypass, debug port latency
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
    rd_addr_a = 4'd3; dbg_addr = 4'd3;
    #1;
    chk("bypass_on",  {16'h0, d0_rd_data_a}, 32'h1234);
    chk("bypass_off", {16'h0, d1_rd_data_a}, 32'h0000);
    tick();
    wr_en = 1'b0;
    #1;
    chk("wr_d0", {16'h0, d0_rd_data_a}, 32'h1234);
    chk("wr_d1", {16'h0, d1_rd_data_a}, 32'h1234);
    chk("dbg_prewrite", {16'h0, d0_dbg_data}, 32'h0000);
    tick();
    chk("dbg_after", {16'h0, d0_dbg_data}, 32'h1234);

    // 3: reserve, conflict, retire
    rsv_en = 1'b1; rsv_addr = 4'd5; rd_addr_a = 4'd5;
    #1;
    chk("busy_no_fwd", {31'h0, d0_rd_busy_a}, 32'h0);
    tick();
    chk("busy5_set", {31'h0, d0_rd_busy_a}, 32'h1);
    chk("no_conflict_first", {31'h0, d0_rsv_conflict}, 32'h0);
    tick();
    rsv_en = 1'b0; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h5555;
    #1;
    chk("conflict5", {31'h0, d0_rsv_conflict}, 32'h1);
    chk("busy5_still", {31'h0, d0_rd_busy_a}, 32'h1);
    tick();
    wr_en = 1'b0;
    #1;
    chk("busy5_retired", {31'h0, d0_rd_busy_a}, 32'h0);
    chk("conflict5_pulse", {31'h0, d0_rsv_conflict}, 32'h0);
    chk("data5", {16'h0, d0_rd_data_a}, 32'h5555);

    // 4: write + reserve on an already-busy r7
    rsv_en = 1'b1; rsv_addr = 4'd7; rd_addr_a = 4'd7;
    tick();
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hBEEF;
    #1;
    chk("busy7_pre", {31'h0, d0_rd_busy_a}, 32'h1);
    tick();
    wr_en = 1'b0; rsv_en = 1'b0;
    #1;
    chk("wr_rsv_conflict", {31'h0, d0_rsv_conflict}, 32'h0);
    chk("wr_rsv_busy7", {31'h0, d0_rd_busy_a}, 32'h1);
    chk("wr_rsv_data7", {16'h0, d0_rd_data_a}, 32'hBEEF);

    // 5: fill, bulk clear with dropped write/reserve
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'h1000 + 16'(i);
      tick();
    end
    wr_en = 1'b0;
    rsv_en = 1'b1; rsv_addr = 4'd9;
    tick();
    rsv_en = 1'b0; rd_addr_a = 4'd0; rd_addr_b = 4'd9;
    #1;
    chk("fill_r0_d0", {16'h0, d0_rd_data_a}, 32'h1000);
    chk("fill_r0_d1", {16'h0, d1_rd_data_a}, 32'h0000);
    chk("busy9", {31'h0, d0_rd_busy_b}, 32'h1);
    chk("fill_r9", {16'h0, d0_rd_data_b}, 32'h1009);
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'hAAAA; rd_addr_a = 4'd4;
    #1;
    chk("idle_wr_bypass", {16'h0, d0_rd_data_a}, 32'hAAAA);
    tick();
    clr_req = 1'b0; wr_en = 1'b0;
    #1;
    chk("clr_busy_on", {31'h0, d0_clr_busy}, 32'h1);
    chk("clr_done_early", {31'h0, d0_clr_done}, 32'h0);
    chk("idle_wr_kept", {16'h0, d1_rd_data_a}, 32'hAAAA);
    tick();
    tick();
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h7777; rd_addr_a = 4'd2;
    #1;
    chk("clear_no_bypass", {16'h0, d0_rd_data_a}, 32'h1002);
    chk("drop_not_yet", {31'h0, d0_wr_drop}, 32'h0);
    tick();
    wr_en = 1'b0; rsv_en = 1'b1; rsv_addr = 4'd12; clr_req = 1'b1;
    #1;
    chk("wr_drop_wr", {31'h0, d0_wr_drop}, 32'h1);
    chk("r2_cleared", {16'h0, d0_rd_data_a}, 32'h0000);
    tick();
    rsv_en = 1'b0; clr_req = 1'b0;
    #1;
    chk("wr_drop_rsv", {31'h0, d0_wr_drop}, 32'h1);
    tick();
    chk("wr_drop_gone", {31'h0, d0_wr_drop}, 32'h0);
    n = 0;
    while (!d0_clr_done && n < 40) begin
      tick();
      n++;
    end
    chk("clr_done_latency", 32'(n), 32'd11);
    chk("clr_busy_off", {31'h0, d0_clr_busy}, 32'h0);
    chk("d1_clr_done", {31'h0, d1_clr_done}, 32'h1);
    tick();
    chk("clr_done_pulse", {31'h0, d0_clr_done}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(i);
      #1;
      chk("cleared_data", {16'h0, d0_rd_data_a}, 32'h0);
      chk("cleared_busy", {31'h0, d0_rd_busy_b}, 32'h0);
    end

    // 6: zero register, then reset during a clear
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; rd_addr_a = 4'd0;
    #1;
    chk("r0_bypass_d0", {16'h0, d0_rd_data_a}, 32'hFFFF);
    chk("r0_zero_d1",   {16'h0, d1_rd_data_a}, 32'h0000);
    tick();
    wr_en = 1'b0; rsv_en = 1'b1; rsv_addr = 4'd0;
    tick();
    chk("r0_busy_d0", {31'h0, d0_rd_busy_a}, 32'h1);
    chk("r0_busy_d1", {31'h0, d1_rd_busy_a}, 32'h0);
    chk("r0_data_d1", {16'h0, d1_rd_data_a}, 32'h0000);
    tick();
    rsv_en = 1'b0;
    #1;
    chk("r0_conflict_d0", {31'h0, d0_rsv_conflict}, 32'h1);
    chk("r0_conflict_d1", {31'h0, d1_rsv_conflict}, 32'h0);
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_clear_busy", {31'h0, d1_clr_busy}, 32'h1);
    reset = 1'b1;
    #2;
    chk("async_rst_busy", {31'h0, d1_clr_busy}, 32'h0);
    chk("async_rst_r0",   {16'h0, d0_rd_data_a}, 32'h0000);
    chk("async_rst_b0",   {31'h0, d0_rd_busy_a}, 32'h0);
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (d0_clr_done || d1_clr_done) n++;
    end
    chk("no_done_after_abort", 32'(n), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
